// File: rtl/scan_phase_counter.sv
// rtl/scan_phase_counter.sv - prescaled 2-bit scan phase generator with advance/wrap strobes
module scan_phase_counter #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic [DIV_W-1:0] DIV,
  output logic [1:0]       D_OUT,
  output logic             TICK,
  output logic             WRAP,
  output logic             BUSY
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  logic             state;
  logic [DIV_W-1:0] pcnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= STATE_IDLE;
      pcnt  <= '0;
      D_OUT <= 2'b00;
      TICK  <= 1'b0;
      WRAP  <= 1'b0;
    end else begin
      // Strobes only survive the edge on which an advance actually happens.
      TICK <= 1'b0;
      WRAP <= 1'b0;
      if (CLR) begin
        D_OUT <= 2'b00;
        pcnt  <= DIV;
        state <= EN ? STATE_RUN : STATE_IDLE;
      end else begin
        case (state)
          STATE_IDLE: begin
            if (EN) begin
              state <= STATE_RUN;
              pcnt  <= DIV;
            end
          end
          default: begin
            if (!EN) begin
              state <= STATE_IDLE;
            end else if (pcnt == '0) begin
              pcnt  <= DIV;
              D_OUT <= D_OUT + 2'd1;
              TICK  <= 1'b1;
              WRAP  <= (D_OUT == 2'd3);
            end else begin
              pcnt <= pcnt - 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign BUSY = (state == STATE_RUN);

endmodule

// File: tb/tb_scan_phase_counter.sv
// tb/tb_scan_phase_counter.sv - self-checking bench for scan_phase_counter
module tb_scan_phase_counter;

  localparam int DIV_W = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             EN;
  logic             CLR;
  logic [DIV_W-1:0] DIV;
  logic [1:0]       D_OUT;
  logic             TICK;
  logic             WRAP;
  logic             BUSY;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: edges remaining until the next advance, phase as an integer.
  bit m_run;
  bit m_tick;
  bit m_wrap;
  int m_phase;
  int m_left;

  scan_phase_counter #(.DIV_W(DIV_W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .CLR  (CLR),
    .DIV  (DIV),
    .D_OUT(D_OUT),
    .TICK (TICK),
    .WRAP (WRAP),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_tick  = 1'b0;
    m_wrap  = 1'b0;
    m_phase = 0;
    m_left  = 0;
  endtask

  task automatic model_edge();
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (CLR) begin
      m_phase = 0;
      m_left  = int'(DIV) + 1;
      m_run   = EN;
    end else if (!m_run) begin
      if (EN) begin
        m_run  = 1'b1;
        m_left = int'(DIV) + 1;
      end
    end else if (!EN) begin
      m_run = 1'b0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_wrap  = (m_phase == 3);
        m_phase = (m_phase + 1) % 4;
        m_tick  = 1'b1;
        m_left  = int'(DIV) + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("d_out", 32'(D_OUT), 32'(m_phase));
    chk("tick",  32'(TICK),  32'(m_tick));
    chk("wrap",  32'(WRAP),  32'(m_wrap));
    chk("busy",  32'(BUSY),  32'(m_run));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    RST = 1'b1;
    EN  = 1'b0;
    CLR = 1'b0;
    DIV = '0;
    model_reset();
    #12;
    chk("reset_d_out", 32'(D_OUT), 32'd0);
    chk("reset_tick",  32'(TICK),  32'd0);
    chk("reset_wrap",  32'(WRAP),  32'd0);
    chk("reset_busy",  32'(BUSY),  32'd0);
    RST = 1'b0;

    // Idle with EN low: nothing moves.
    run(3);

    // DIV=3 steady run.
    DIV = 8'd3;
    EN  = 1'b1;
    run(20);

    // DIV=0: advance every edge.
    EN = 1'b0;
    run(1);
    CLR = 1'b1;
    DIV = 8'd0;
    run(1);
    CLR = 1'b0;
    EN  = 1'b1;
    run(12);

    // DIV=5 with an EN gap two cycles into a period.
    DIV = 8'd5;
    CLR = 1'b1;
    run(1);
    CLR = 1'b0;
    run(2);
    EN = 1'b0;
    run(3);
    EN = 1'b1;
    run(14);

    // CLR coincident with a 3->0 advance.
    DIV = 8'd2;
    for (int i = 0; i < 100 && !(m_run && m_phase == 3 && m_left == 1); i++) step();
    chk("clr_setup_reached", 32'(m_run && m_phase == 3 && m_left == 1), 32'd1);
    CLR = 1'b1;
    step();
    chk("clr_wins_d_out", 32'(D_OUT), 32'd0);
    chk("clr_wins_tick",  32'(TICK),  32'd0);
    CLR = 1'b0;
    run(8);

    // DIV changed 7->1 mid-period.
    DIV = 8'd7;
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    run(3);
    DIV = 8'd1;
    run(14);

    // Asynchronous reset while D_OUT=2.
    DIV = 8'd4;
    for (int i = 0; i < 100 && !(m_run && m_phase == 2); i++) step();
    chk("rst_setup_reached", 32'(m_run && m_phase == 2), 32'd1);
    #3 RST = 1'b1;
    #1;
    chk("async_rst_d_out", 32'(D_OUT), 32'd0);
    chk("async_rst_tick",  32'(TICK),  32'd0);
    chk("async_rst_wrap",  32'(WRAP),  32'd0);
    chk("async_rst_busy",  32'(BUSY),  32'd0);
    model_reset();
    #2 RST = 1'b0;
    run(12);

    // Maximum divisor: period of 256 edges, two full periods.
    DIV = 8'hFF;
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    run(520);

    // Randomized mix of enables, clears and divisors.
    for (int i = 0; i < 400; i++) begin
      EN  = ($urandom_range(0, 9) != 0);
      CLR = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0)
        DIV = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
